fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC register. Takes the current pc,
//  issues one instruction-memory read at a time and buffers {pc, instr} pairs in a small FIFO
//  for decode. Drives pc_en back to the PC register, so the PC only advances when its fetch is accepted.
//  flush (taken branch, i.e. PCsrc) discards all in-flight and buffered instructions.
// PARAMETERS
//  WIDTH  32  address/data width
//  DEPTH  2   FIFO entries; power of two, >=2
// PORTS
//  clk             in   1      clock; all state updates on rising edge
//  rst             in   1      asynchronous, active-high reset
//  pc              in   WIDTH  current PC from the PC register
//  flush           in   1      taken branch/jump; PC register loads target this cycle
//  pc_en           out  1      PC register load enable
//  imem_req_valid  out  1      read request valid
//  imem_req_ready  in   1      memory accepts request
//  imem_addr       out  WIDTH  read address = {pc[WIDTH-1:2],2'b00}
//  imem_rsp_valid  in   1      read data valid; earliest 1 cycle after accept, 1-cycle pulse
//  imem_rsp_data   in   WIDTH  read data
//  instr_valid     out  1      FIFO head valid
//  instr_ready     in   1      decode consumes head
//  instr           out  WIDTH  FIFO head instruction
//  instr_pc        out  WIDTH  FIFO head address
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; FIFO empty. Reset mid-operation drops everything; a late rsp is ignored (IDLE).
//  FSM states IDLE, REQ, WAIT, DROP:
//   IDLE -> REQ unconditionally on first clock after rst deasserts.
//   REQ:  imem_req_valid = !flush && count<DEPTH. Accept (valid&&ready) -> WAIT, latch addr.
//   WAIT: rsp_valid && !flush -> push {addr,data}, -> REQ. rsp_valid && flush -> discard, -> REQ.
//         flush without rsp -> DROP.
//   DROP: wait for rsp_valid, discard data, -> REQ. flush in DROP: stay DROP.
//  pc_en = accept || flush (single-cycle pulses; never asserted in IDLE).
//  At most one outstanding request; issue check count<DEPTH guarantees push never hits full.
//  FIFO: registered outputs; instr_valid = count!=0; pop on instr_valid&&instr_ready.
//   Push+pop same cycle: count unchanged. Pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits.
//   flush: count<=0, pointers<=0 next edge; any same-cycle pop/push is ignored.
//  Latency: accept at T, rsp at T+1 -> instr_valid at T+2. Throughput 1 instr / 2 cycles with 1-cycle memory.
//  instr/instr_pc hold last head value when instr_valid=0 (0 after reset).
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: adds output instr_fault (1 bit, reset 0). In REQ with pc[1:0]!=0,
//   no request is issued. Once FIFO empties, head shows instr_valid=1, instr_fault=1, instr=0, instr_pc=pc.
//   It holds until flush; popping does not clear it.
//  Undefined: no instr_fault port; pc[1:0] ignored (address forced aligned).
// STRUCTURE
//  fetch_pkg: fetch_state_e enum {IDLE,REQ,WAIT,DROP}; fetch_entry_t struct {pc,instr}.
//  Sub-module fetch_fifo (DEPTH x fetch_entry_t, push/pop/clear, count out).
//  fetch_unit holds the FSM, address latch and handshake logic.
// TESTING
//  1 rst pulse -> all outputs 0 and stay 0 during reset; first req_valid exactly 1 cycle after release.
//  2 pc=0x0, ready=1, rsp next cycle data=0x00500093 -> pc_en 1 cycle;
//    instr_valid at T+2 with instr=0x00500093, instr_pc=0x0.
//  3 instr_ready=0, pc 0x0,0x4 fetched -> after 2 pushes req_valid=0, pc_en=0.
//    One pop -> next req within 1 cycle; order preserved.
//  4 flush in WAIT, rsp 3 cycles later -> state DROP, rsp discarded, instr_valid stays 0; next req uses new pc.
//  5 flush same cycle as rsp_valid and a pop with count=1 -> FIFO empty next cycle; pc_en=1 that cycle.
//  6 macro on, pc=0x6 -> no imem_req_valid; instr_valid=1, instr_fault=1, instr_pc=0x6; flush clears it.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types for the instruction-fetch stage. It defines the
//            fetch FSM state encoding, the {pc, instr} FIFO entry and a
//            word-alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Width of one FIFO entry field. The fetch_unit WIDTH parameter must
    // match this value.
    localparam int FETCH_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [FETCH_XLEN-1:0] word_align(input logic [FETCH_XLEN-1:0] addr);
        return {addr[FETCH_XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry FIFO of fetch_entry_t with a registered head output.
//            The head register always holds the entry at the read pointer.
//            When the FIFO is empty it keeps the last head value.
// Ports    : clk, rst (async, active-high)
//            push / din   - write an entry (ignored when full)
//            pop          - drop the head entry (ignored when empty)
//            clear        - empty the FIFO; same-cycle push/pop are ignored
//            head         - registered head entry
//            count        - number of valid entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fetch_entry_t           din,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    fetch_entry_t     head_q, head_d;
    logic             w_push_en;
    logic             w_pop_en;

    always_comb begin
        w_push_en = push && (count_q != C_FULL);
        w_pop_en  = pop && (count_q != '0);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        head_d    = head_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push_en) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
            end
            if (w_pop_en) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            case ({w_push_en, w_pop_en})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
            // The new head is the entry being written this cycle exactly when
            // the write slot equals the next read slot. That happens only when
            // the FIFO holds one entry afterwards. Otherwise the entry is
            // already in storage.
            if (count_d != '0) begin
                head_d = (w_push_en && (wr_ptr_q == rd_ptr_d)) ? din : mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage behind the PC register. It issues one
//            instruction-memory read at a time and buffers {pc, instr} pairs
//            for decode. pc_en advances the PC only when its fetch is
//            accepted, or on a flush. A flush discards the in-flight fetch
//            and all buffered entries.
// Ports    : clk, rst (async, active-high), pc, flush, pc_en
//            imem_req_valid/ready, imem_addr   - read request channel
//            imem_rsp_valid, imem_rsp_data     - read response (1-cycle pulse)
//            instr_valid/ready, instr, instr_pc - decode-side FIFO head
//            instr_fault (only with FETCH_MISALIGN_CHECK_EN)
// Config   : FETCH_MISALIGN_CHECK_EN - when defined, a misaligned pc issues
//            no request. Instead, once the FIFO is empty, the stage presents
//            a faulting head until the next flush. When undefined, pc[1:0]
//            is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             flush,
    output logic             pc_en,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic             instr_fault
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] w_aligned_pc;
    logic             w_misaligned;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_fifo_count;
    fetch_entry_t     w_fifo_head;
    fetch_entry_t     w_fifo_din;

    assign w_aligned_pc = word_align(pc);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_misaligned = (pc[1:0] != 2'b00);
`else
    logic w_unused_pc_lsb;
    assign w_misaligned    = 1'b0;
    assign w_unused_pc_lsb = ^pc[1:0];
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = w_accept ? w_aligned_pc : addr_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ:  if (w_accept) state_d = WAIT;
            WAIT: begin
                // A response in the flush cycle is discarded on the spot.
                // A flush without a response must absorb the late response.
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: if (imem_rsp_valid) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_valid = 1'b0;
        imem_addr      = '0;
        w_push         = 1'b0;
        unique case (state_q)
            REQ: begin
                // A request is issued only when the FIFO has room, so the
                // response push can never meet a full FIFO.
                imem_req_valid = !flush && (w_fifo_count < C_FULL) && !w_misaligned;
                imem_addr      = w_aligned_pc;
            end
            WAIT:    w_push = imem_rsp_valid && !flush;
            default: ;
        endcase
        w_accept = imem_req_valid && imem_req_ready;
        pc_en    = w_accept || (flush && (state_q != IDLE));
    end

    assign w_pop      = instr_ready && (w_fifo_count != '0);
    assign w_fifo_din = '{pc: addr_q, instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .clear (flush),
        .din   (w_fifo_din),
        .head  (w_fifo_head),
        .count (w_fifo_count)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic             fault_q, fault_d;
    logic [WIDTH-1:0] fault_pc_q, fault_pc_d;

    // The fault is raised only after older instructions have drained. It
    // stays sticky until the flush that redirects the PC.
    always_comb begin
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (flush) begin
            fault_d = 1'b0;
        end else if (!fault_q && (state_q == REQ) && w_misaligned && (w_fifo_count == '0)) begin
            fault_d    = 1'b1;
            fault_pc_d = pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign instr_fault = fault_q;
    assign instr_valid = fault_q || (w_fifo_count != '0);
    assign instr       = fault_q ? '0 : w_fifo_head.instr;
    assign instr_pc    = fault_q ? fault_pc_q : w_fifo_head.pc;
`else
    assign instr_valid = (w_fifo_count != '0);
    assign instr       = w_fifo_head.instr;
    assign instr_pc    = w_fifo_head.pc;
`endif

endmodule
`default_nettype wire
